// File: rtl/lcd_pixel_unpacker.sv
// Unpacks 32-bit FWFT FIFO words (3 words = 4 pixels, MSB first) into a registered 24-bit RGB stream.
// One-cycle load-to-valid latency; with valid high and ready low, pixel, phase, residual hold and no pop occurs.
module lcd_pixel_unpacker (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_fifoData,
    input  logic        i_fifoEmpty,
    output logic        o_fifoRead,
    input  logic        i_flush,
    output logic [23:0] o_pixelData,
    output logic        o_pixelValid,
    input  logic        i_pixelReady,
    output logic        o_starved
);

    typedef enum logic [1:0] {
        PH_W0  = 2'd0,
        PH_W1  = 2'd1,
        PH_W2  = 2'd2,
        PH_RES = 2'd3
    } phase_e;

    phase_e      phase_q, phase_d;
    logic [23:0] residual_q, residual_d;
    logic [23:0] pixel_q, pixel_d;
    logic        valid_q, valid_d;
    logic        starved_q, starved_d;
    logic        load_slot;
    logic        has_src;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            phase_q    <= PH_W0;
            residual_q <= 24'h000000;
            pixel_q    <= 24'h000000;
            valid_q    <= 1'b0;
            starved_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            residual_q <= residual_d;
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            starved_q  <= starved_d;
        end
    end

    always_comb begin
        load_slot  = !valid_q || i_pixelReady;
        // The residual-only phase completes a pixel without touching the FIFO.
        has_src    = (phase_q == PH_RES) || !i_fifoEmpty;
        o_fifoRead = load_slot && (phase_q != PH_RES) && !i_fifoEmpty && !i_flush && !i_reset;

        phase_d    = phase_q;
        residual_d = residual_q;
        pixel_d    = pixel_q;
        valid_d    = valid_q;
        starved_d  = 1'b0;

        if (i_flush) begin
            phase_d    = PH_W0;
            residual_d = 24'h000000;
            valid_d    = 1'b0;
        end else if (load_slot) begin
            if (has_src) begin
                valid_d = 1'b1;
                case (phase_q)
                    PH_W0: begin
                        pixel_d    = i_fifoData[31:8];
                        residual_d = {i_fifoData[7:0], residual_q[15:0]};
                        phase_d    = PH_W1;
                    end
                    PH_W1: begin
                        pixel_d    = {residual_q[23:16], i_fifoData[31:16]};
                        residual_d = {i_fifoData[15:0], residual_q[7:0]};
                        phase_d    = PH_W2;
                    end
                    PH_W2: begin
                        pixel_d    = {residual_q[23:8], i_fifoData[31:24]};
                        residual_d = i_fifoData[23:0];
                        phase_d    = PH_RES;
                    end
                    PH_RES: begin
                        pixel_d    = residual_q;
                        residual_d = 24'h000000;
                        phase_d    = PH_W0;
                    end
                    default: begin
                        phase_d = PH_W0;
                    end
                endcase
            end else begin
                // A load slot with valid high means the pixel was just accepted.
                valid_d   = 1'b0;
                starved_d = 1'b1;
            end
        end
    end

    assign o_pixelData  = pixel_q;
    assign o_pixelValid = valid_q;
    assign o_starved    = starved_q;

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// Bench for lcd_pixel_unpacker: byte-queue reference model checked every cycle plus directed literal pixel checks.
module tb_lcd_pixel_unpacker;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_fifoData;
    logic        i_fifoEmpty;
    logic        o_fifoRead;
    logic        i_flush;
    logic [23:0] o_pixelData;
    logic        o_pixelValid;
    logic        i_pixelReady;
    logic        o_starved;

    lcd_pixel_unpacker dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_fifoData   (i_fifoData),
        .i_fifoEmpty  (i_fifoEmpty),
        .o_fifoRead   (o_fifoRead),
        .i_flush      (i_flush),
        .o_pixelData  (o_pixelData),
        .o_pixelValid (o_pixelValid),
        .i_pixelReady (i_pixelReady),
        .o_starved    (o_starved)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int starve_cnt = 0;

    logic [31:0] fifo[$];
    logic [7:0]  mbytes[$];
    logic [23:0] acc[$];
    int          acc_cyc[$];
    logic [23:0] exp_q[$];

    logic        m_valid;
    logic [23:0] m_data;
    logic        m_starved;
    logic        pend_pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic upd();
        i_fifoEmpty = (fifo.size() == 0);
        i_fifoData  = (fifo.size() != 0) ? fifo[0] : 32'h0;
    endtask

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        upd();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_stats();
        acc.delete();
        acc_cyc.delete();
        exp_q.delete();
        pop_cnt = 0;
        starve_cnt = 0;
    endtask

    task automatic check_acc(input string name);
        check({name, "_count"}, acc.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < acc.size()) check($sformatf("%s_px%0d", name, i), {8'h0, acc[i]}, {8'h0, exp_q[i]});
        end
    endtask

    // Reference model: residual bytes kept as a queue; a pixel needs three bytes,
    // and a word is fetched only when fewer than three are buffered.
    initial begin
        m_valid = 1'b0;
        m_data = 24'h0;
        m_starved = 1'b0;
        pend_pop = 1'b0;
        forever begin
            logic slot;
            logic exp_pop;
            @(negedge clk);
            cyc++;
            pend_pop = 1'b0;
            if (i_reset) begin
                check("rst_valid", o_pixelValid, 1'b0);
                check("rst_starved", o_starved, 1'b0);
                check("rst_data", o_pixelData, 24'h0);
                check("rst_read", o_fifoRead, 1'b0);
                mbytes.delete();
                m_valid = 1'b0;
                m_data = 24'h0;
                m_starved = 1'b0;
            end else begin
                check("valid", o_pixelValid, m_valid);
                check("starved", o_starved, m_starved);
                if (m_valid) check("data", o_pixelData, m_data);
                if (o_pixelValid && i_pixelReady && !i_flush) begin
                    acc.push_back(o_pixelData);
                    acc_cyc.push_back(cyc);
                end
                if (o_starved) starve_cnt++;
                if (o_fifoRead) pop_cnt++;

                slot = !m_valid || i_pixelReady;
                exp_pop = 1'b0;
                if (i_flush) begin
                    mbytes.delete();
                    m_valid = 1'b0;
                    m_starved = 1'b0;
                end else if (slot) begin
                    if (mbytes.size() < 3 && fifo.size() != 0) begin
                        for (int b = 3; b >= 0; b--) mbytes.push_back(fifo[0][b*8 +: 8]);
                        exp_pop = 1'b1;
                    end
                    if (mbytes.size() >= 3) begin
                        m_data = {mbytes[0], mbytes[1], mbytes[2]};
                        repeat (3) void'(mbytes.pop_front());
                        m_valid = 1'b1;
                        m_starved = 1'b0;
                    end else begin
                        m_valid = 1'b0;
                        m_starved = 1'b1;
                    end
                end else begin
                    m_starved = 1'b0;
                end
                check("fifo_read", o_fifoRead, exp_pop);
                pend_pop = exp_pop;
            end
            @(posedge clk);
            #1;
            if (pend_pop && !i_reset && fifo.size() != 0) begin
                void'(fifo.pop_front());
                upd();
            end
        end
    end

    initial begin
        int p;
        i_reset = 1'b1;
        i_flush = 1'b0;
        i_pixelReady = 1'b0;
        upd();
        step(2);
        i_reset = 1'b0;
        step(1);

        // Basic group of three words
        clear_stats();
        i_pixelReady = 1'b1;
        push(32'h11223344); push(32'h55667788); push(32'h99AABBCC);
        step(8);
        exp_q = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        check_acc("basic");
        if (acc_cyc.size() == 4) check("basic_span", acc_cyc[3] - acc_cyc[0], 3);
        check("basic_pops", pop_cnt, 3);

        // Six words back to back
        clear_stats();
        push(32'h00010203); push(32'h04050607); push(32'h08090A0B);
        push(32'h0C0D0E0F); push(32'h10111213); push(32'h14151617);
        step(12);
        exp_q = '{24'h000102, 24'h030405, 24'h060708, 24'h090A0B,
                  24'h0C0D0E, 24'h0F1011, 24'h121314, 24'h151617};
        check_acc("six");
        if (acc_cyc.size() == 8) check("six_span", acc_cyc[7] - acc_cyc[0], 7);
        check("six_pops", pop_cnt, 6);
        check("six_starved_seen", starve_cnt != 0, 1'b1);

        // Ready toggling 1,0,0,1
        clear_stats();
        push(32'h11223344); push(32'h55667788); push(32'h99AABBCC);
        for (int k = 0; k < 16; k++) begin
            i_pixelReady = (k % 4 == 0) || (k % 4 == 3);
            step(1);
        end
        i_pixelReady = 1'b1;
        step(2);
        exp_q = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        check_acc("toggle");
        check("toggle_pops", pop_cnt, 3);

        // Starvation gap between words
        clear_stats();
        push(32'h11223344);
        step(6);
        p = cyc;
        push(32'h55667788);
        step(4);
        exp_q = '{24'h112233, 24'h445566};
        check_acc("starve");
        if (acc_cyc.size() == 2) check("starve_resume_cyc", acc_cyc[1], p + 2);
        check("starve_seen", starve_cnt != 0, 1'b1);

        // Flush discards the buffered 0x77,0x88
        clear_stats();
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        push(32'hAABBCCDD);
        step(4);
        exp_q = '{24'hAABBCC};
        check_acc("flush");

        // Async reset while a stalled pixel is valid
        clear_stats();
        i_pixelReady = 1'b0;
        push(32'h11223344); push(32'h55667788);
        step(4);
        check("stall_valid", o_pixelValid, 1'b1);
        check("stall_data", o_pixelData, 24'hDD1122);
        @(posedge clk);
        #2 i_pixelReady = 1'b1;
        #1 i_reset = 1'b1;
        #1;
        check("async_valid", o_pixelValid, 1'b0);
        check("async_read", o_fifoRead, 1'b0);
        @(posedge clk);
        #2 i_reset = 1'b0;
        clear_stats();
        step(4);
        exp_q = '{24'h556677};
        check_acc("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
